fifo_control_unit: RTL

FIFO_CONTROL_UNIT -- requirements
Module: fifo_control_unit

---
 rtl/fifo_control_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_control_unit.sv
// rtl/fifo_control_unit.sv - FIFO pointer/occupancy controller for an external register file (optional macro FIFO_ERR_FLAG_EN)
module fifo_control_unit #(
    parameter int ADDR_W    = 5,
    parameter int AFULL_TH  = 28,
    parameter int AEMPTY_TH = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iPush,
    input  logic              iPop,
    output logic              oWr,
    output logic [ADDR_W-1:0] oWrAddr,
    output logic              oRd,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic              oFull,
    output logic              oEmpty,
    output logic              oAFull,
    output logic              oAEmpty,
    output logic [ADDR_W:0]   oCount,
    output logic              oOvf,
    output logic              oUdf
);

    localparam logic [ADDR_W:0] DEPTH_C  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
    localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit; the register file only sees the low bits.
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] count_q,  count_d;
    logic            push_acc;
    logic            pop_acc;
    logic            full;
    logic            empty;

    // Status flags decode straight from the registered occupancy.
    always_comb begin
        full    = (count_q == DEPTH_C);
        empty   = (count_q == '0);
        oFull   = full;
        oEmpty  = empty;
        oAFull  = (count_q >= AFULL_C);
        oAEmpty = (count_q <= AEMPTY_C);
        oCount  = count_q;
        oWrAddr = wr_ptr_q[ADDR_W-1:0];
        oRdAddr = rd_ptr_q[ADDR_W-1:0];
        oRd     = ~empty;
    end

    // Acceptance: a full FIFO still takes a push paired with a pop (the pop frees
    // the slot being overwritten); an empty FIFO never lets data fall through.
    always_comb begin
        push_acc = iPush & (~full | iPop);
        pop_acc  = iPop & ~empty;
        oWr      = push_acc & ~iRst;
    end

    // Next-state pointer and occupancy arithmetic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end
        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared immediately by reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags: any push or pop request that was not accepted.
    always_comb begin
        ovf_d = ovf_q | (iPush & ~push_acc);
        udf_d = udf_q | (iPop & ~pop_acc);
    end

    // Error flag registers, held until reset.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign oOvf = ovf_q;
    assign oUdf = udf_q;
`else
    assign oOvf = 1'b0;
    assign oUdf = 1'b0;
`endif

endmodule
